// File: rtl/mem_pkg.sv
// mem_pkg: constants and FSM encoding shared by the block memory
// and the write-back cache in front of it.
package mem_pkg;

  localparam int ADDR_W      = 10;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = 4;
  localparam int LATENCY     = 8;

  localparam int WIDX_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WIDX_W;
  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int BLK_W  = ADDR_W - OFFSET_W;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_e;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x WORD_W single-port RAM, synchronous write and
// registered synchronous read, one access per cycle.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [WIDX_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Storage is never cleared; only the read register resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/block_memory.sv
// block_memory: fixed-latency block store behind the cache; one
// request moves a 4-word block as a burst of Done-strobed beats.
module block_memory
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              read_write_mem,
  input  logic [ADDR_W-1:0] address_mem,
  input  logic [WORD_W-1:0] write_data_mem,
  output logic [WORD_W-1:0] read_data_mem,
  output logic              Done,
  output logic              busy
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LAT_W-1:0]  r_lat;
  logic [BEAT_W-1:0] r_beat;
  logic [BLK_W-1:0]  r_blk;
  logic              r_wr;
  logic              r_done;
  logic              r_busy;
  logic [WIDX_W-1:0] r_cur;

  logic              w_accept;
  logic              w_issue;
  logic              w_we;
  logic              w_re;
  logic [WIDX_W-1:0] w_issue_word;
  logic [WIDX_W-1:0] w_addr;
  logic              w_unused_ofs;

  assign w_unused_ofs = ^address_mem[OFFSET_W-1:0];

  // Beat index fills the low word bits, so it never carries into the block.
  assign w_issue_word = {r_blk, r_beat};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_lat == '0) begin
          w_issue     = 1'b1;
          w_state_nxt = (r_beat == LAST_BEAT) ? IDLE : BURST;
        end
      end
      BURST: begin
        w_issue = 1'b1;
        if (r_beat == LAST_BEAT) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A beat is issued one edge ahead of its Done cycle; the FSM is
  // back in IDLE while the last beat is still on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat  <= '0;
      r_beat <= '0;
      r_blk  <= '0;
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_cur  <= '0;
    end else begin
      if (w_accept) begin
        r_lat  <= LAT_LOAD;
        r_beat <= '0;
        r_blk  <= address_mem[ADDR_W-1:OFFSET_W];
        r_wr   <= read_write_mem;
      end else if (r_state == WAIT && r_lat != '0) begin
        r_lat <= r_lat - 1'b1;
      end
      if (w_issue) begin
        r_beat <= r_beat + 1'b1;
        r_cur  <= w_issue_word;
      end
      r_done <= w_issue;
      r_busy <= w_accept | (r_state != IDLE);
    end
  end

  assign w_we   = r_done & r_wr & ~rst;
  assign w_re   = w_issue & ~r_wr;
  assign w_addr = w_we ? r_cur : w_issue_word;

  mem_array u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (write_data_mem),
    .o_rdata (read_data_mem)
  );

  assign Done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory: randomized block transfers checked cycle by cycle
// against a word-array model and the request timeline.
module tb_block_memory;

  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rw;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  block_memory dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .read_write_mem (rw),
    .address_mem    (addr),
    .write_data_mem (wdata),
    .read_data_mem  (rdata),
    .Done           (done),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      wdata = $urandom;
      step();
    end
  endtask

  task automatic issue(input logic w, input logic [9:0] a);
    req  = 1'b1;
    rw   = w;
    addr = a;
    step();
  endtask

  // Called right after the accepting edge. mode 1: extra req pulses in
  // WAIT; mode 2: req on the last-beat edge; mode 3: reset on beat 2.
  task automatic xact(input logic w, input logic [9:0] a,
                      input logic [31:0] wd [4], input int mode,
                      input logic chain, input logic nw,
                      input logic [9:0] na);
    int base;
    base = int'(a[9:4]) * 4;
    for (int s = 0; s <= L + 3; s++) begin
      if (s == 0) begin
        req  = 1'b0;
        rw   = 1'($urandom);
        addr = 10'($urandom);
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(s >= L));
      if (!w && s >= L) begin
        chk("rdata", rdata, ref_mem[base + s - L]);
      end
      wdata = $urandom;
      if (w && s >= L) wdata = wd[s-L];
      if (mode == 1 && (s == 2 || s == 4)) begin
        req  = 1'b1;
        addr = 10'($urandom);
      end
      if (mode == 1 && (s == 3 || s == 5)) req = 1'b0;
      if (mode == 2 && s == L + 2) req = 1'b1;
      if (mode == 2 && s == L + 3) req = 1'b0;
      if (mode == 3 && s == L + 2) rst = 1'b1;
      if (w && s >= L && !rst) ref_mem[base + s - L] = wd[s-L];
      if (chain && s == L + 3) begin
        req  = 1'b1;
        rw   = nw;
        addr = na;
      end
      step();
      if (rst) begin
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        return;
      end
    end
    if (chain) begin
      chk("chain_busy", 32'(busy), 32'd1);
    end else begin
      chk("end_busy", 32'(busy), 32'd0);
    end
    chk("end_done", 32'(done), 32'd0);
  endtask

  task automatic one(input logic w, input logic [9:0] a,
                     input logic [31:0] wd [4], input int mode);
    issue(w, a);
    xact(w, a, wd, mode, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wd [4];
    logic        cw;
    logic        nw;
    logic        ch;
    logic [9:0]  ca;
    logic [9:0]  na;

    rst   = 1'b1;
    req   = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    step();
    step();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst = 1'b0;
    idle(2);

    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      one(1'b1, 10'(b * 16), wd, 0);
    end

    wd = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
    one(1'b1, 10'h040, wd, 0);
    one(1'b0, 10'h04C, wd, 0);
    one(1'b0, 10'h040, wd, 1);
    idle(L + 6);

    for (int k = 0; k < 4; k++) wd[k] = 32'hFFFF_0000 + 32'(k);
    one(1'b1, 10'h3F0, wd, 0);
    one(1'b0, 10'h3F0, wd, 0);
    one(1'b0, 10'h000, wd, 0);

    wd = '{32'hB0B0_B0B0, 32'hB1B1_B1B1, 32'hB2B2_B2B2, 32'hB3B3_B3B3};
    one(1'b1, 10'h080, wd, 3);
    idle(2);
    one(1'b0, 10'h080, wd, 0);

    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    issue(1'b1, 10'h100);
    xact(1'b1, 10'h100, wd, 0, 1'b1, 1'b0, 10'h200);
    xact(1'b0, 10'h200, wd, 0, 1'b0, 1'b0, 10'd0);
    one(1'b0, 10'h100, wd, 0);

    one(1'b0, 10'h040, wd, 2);
    idle(L + 4);

    cw = 1'($urandom);
    ca = 10'($urandom);
    issue(cw, ca);
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) wd[k] = $urandom;
      nw = 1'($urandom);
      na = 10'($urandom);
      ch = (i != 39) && ($urandom_range(1) == 1);
      xact(cw, ca, wd, 0, ch, nw, na);
      if (i != 39 && !ch) begin
        idle($urandom_range(2));
        issue(nw, na);
      end
      cw = nw;
      ca = na;
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
